pipe_hazard_unit: RTL and testbench

- Parametrised hazard and forwarding controller for the in-order RV32I pipeline.
- Tracks in-flight register writers in a shift-register scoreboard covering PIPE_DEPTH stages after decode.
- Generates stall, flush and operand-forwarding selects.
- Generalises to any pipeline depth, register count and load-result latency, so the core can run back-to-back dependent instructions without software NOPs.

---
 rtl/pipe_pkg.sv | 17 +
 rtl/pipe_hazard_unit_if.sv | 37 +++
 rtl/pipe_hazard_match.sv | 35 +++
 rtl/pipe_hazard_unit.sv | 100 ++++++++++
 tb/tb_pipe_hazard_unit.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline constants and the hazard scoreboard entry type
package pipe_pkg;

    localparam int XLEN    = 32;
    localparam int ILEN    = 32;
    localparam int HZ_RD_W = 8;
    localparam int FWD_RF  = 0;

    // rd is held at a fixed maximum width so the entry type is independent of NREG
    typedef struct packed {
        logic               valid;
        logic [HZ_RD_W-1:0] rd;
        logic               we;
        logic               is_load;
    } hz_entry_t;

endpackage

// File: rtl/pipe_hazard_unit_if.sv
// rtl/pipe_hazard_unit_if.sv - decode/execute to hazard unit signal bundle
interface pipe_hazard_unit_if #(
    parameter int NREG       = 32,
    parameter int PIPE_DEPTH = 3
);
    localparam int RIDX_W = $clog2(NREG);
    localparam int FWD_W  = $clog2(PIPE_DEPTH + 1);

    logic              id_valid;
    logic [RIDX_W-1:0] id_rs1;
    logic              id_rs1_used;
    logic [RIDX_W-1:0] id_rs2;
    logic              id_rs2_used;
    logic [RIDX_W-1:0] id_rd;
    logic              id_rd_we;
    logic              id_is_load;
    logic              ex_redirect;
    logic              stall_fd;
    logic              flush_fd;
    logic              flush_dx;
    logic [FWD_W-1:0]  fwd_a_sel;
    logic [FWD_W-1:0]  fwd_b_sel;
    logic [NREG-1:0]   busy_vec;

    modport master (
        output id_valid, id_rs1, id_rs1_used, id_rs2, id_rs2_used,
               id_rd, id_rd_we, id_is_load, ex_redirect,
        input  stall_fd, flush_fd, flush_dx, fwd_a_sel, fwd_b_sel, busy_vec
    );

    modport slave (
        input  id_valid, id_rs1, id_rs1_used, id_rs2, id_rs2_used,
               id_rd, id_rd_we, id_is_load, ex_redirect,
        output stall_fd, flush_fd, flush_dx, fwd_a_sel, fwd_b_sel, busy_vec
    );

endinterface

// File: rtl/pipe_hazard_match.sv
// rtl/pipe_hazard_match.sv - per-source youngest-writer priority matcher over the scoreboard
module pipe_hazard_match
    import pipe_pkg::*;
#(
    parameter int PIPE_DEPTH = 3,
    parameter int RIDX_W     = 5,
    parameter int FWD_W      = 2
) (
    input  hz_entry_t [PIPE_DEPTH:1] i_sb,
    input  logic [RIDX_W-1:0]        i_src,
    input  logic                     i_used,
    output logic                     o_hit,
    output logic [FWD_W-1:0]         o_stage,
    output logic                     o_is_load
);

    logic w_src_live;
    assign w_src_live = i_used & (i_src != '0);

    // Scan oldest to youngest so the last hit written is the smallest stage
    always_comb begin
        o_hit     = 1'b0;
        o_stage   = FWD_W'(FWD_RF);
        o_is_load = 1'b0;
        for (int k = PIPE_DEPTH; k >= 1; k--) begin
            if (w_src_live && i_sb[k].valid && i_sb[k].we &&
                (i_sb[k].rd == HZ_RD_W'(i_src))) begin
                o_hit     = 1'b1;
                o_stage   = FWD_W'(k);
                o_is_load = i_sb[k].is_load;
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_unit.sv
// rtl/pipe_hazard_unit.sv - stall/flush/forward controller; HAZARD_FWD_EN enables forwarding
module pipe_hazard_unit
    import pipe_pkg::*;
#(
    parameter int NREG       = 32,
    parameter int PIPE_DEPTH = 3,
    parameter int LOAD_STAGE = 2
) (
    input  logic              clk,
    input  logic              rst,
    pipe_hazard_unit_if.slave hz
);

    localparam int RIDX_W = $clog2(NREG);
    localparam int FWD_W  = $clog2(PIPE_DEPTH + 1);

    hz_entry_t [PIPE_DEPTH:1] r_sb;
    hz_entry_t                w_ins;

    logic             w_hit_a, w_ld_a, w_hit_b, w_ld_b;
    logic [FWD_W-1:0] w_stg_a, w_stg_b;
    logic             w_hz_a, w_hz_b, w_stall;
    logic [FWD_W-1:0] w_fwd_a, w_fwd_b;
    logic [NREG-1:0]  w_busy;

    pipe_hazard_match #(.PIPE_DEPTH(PIPE_DEPTH), .RIDX_W(RIDX_W), .FWD_W(FWD_W)) u_match_a (
        .i_sb      (r_sb),
        .i_src     (hz.id_rs1),
        .i_used    (hz.id_rs1_used),
        .o_hit     (w_hit_a),
        .o_stage   (w_stg_a),
        .o_is_load (w_ld_a)
    );

    pipe_hazard_match #(.PIPE_DEPTH(PIPE_DEPTH), .RIDX_W(RIDX_W), .FWD_W(FWD_W)) u_match_b (
        .i_sb      (r_sb),
        .i_src     (hz.id_rs2),
        .i_used    (hz.id_rs2_used),
        .o_hit     (w_hit_b),
        .o_stage   (w_stg_b),
        .o_is_load (w_ld_b)
    );

`ifdef HAZARD_FWD_EN
    assign w_hz_a  = w_hit_a & w_ld_a & (w_stg_a < FWD_W'(LOAD_STAGE));
    assign w_hz_b  = w_hit_b & w_ld_b & (w_stg_b < FWD_W'(LOAD_STAGE));
    assign w_fwd_a = w_stg_a;
    assign w_fwd_b = w_stg_b;
`else
    // Interlock-only: the writeback-stage writer is visible through the regfile
    assign w_hz_a  = w_hit_a & (w_stg_a < FWD_W'(PIPE_DEPTH));
    assign w_hz_b  = w_hit_b & (w_stg_b < FWD_W'(PIPE_DEPTH));
    assign w_fwd_a = FWD_W'(FWD_RF);
    assign w_fwd_b = FWD_W'(FWD_RF);

    logic w_unused_ld;
    assign w_unused_ld = ^{w_ld_a, w_ld_b, 32'(LOAD_STAGE)};
`endif

    // A taken redirect kills the decode instruction, so it overrides the stall
    assign w_stall = hz.id_valid & (w_hz_a | w_hz_b) & ~hz.ex_redirect;

    always_comb begin
        w_ins = '0;
        if (hz.id_valid && !w_stall && !hz.ex_redirect) begin
            w_ins.valid   = 1'b1;
            w_ins.rd      = HZ_RD_W'(hz.id_rd);
            w_ins.we      = hz.id_rd_we & (hz.id_rd != '0);
            w_ins.is_load = hz.id_is_load;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sb <= '0;
        end else begin
            r_sb[1] <= w_ins;
            for (int k = 2; k <= PIPE_DEPTH; k++) begin
                r_sb[k] <= r_sb[k-1];
            end
        end
    end

    always_comb begin
        w_busy = '0;
        for (int k = 1; k <= PIPE_DEPTH; k++) begin
            if (r_sb[k].valid && r_sb[k].we) begin
                w_busy[r_sb[k].rd[RIDX_W-1:0]] = 1'b1;
            end
        end
    end

    assign hz.stall_fd  = rst & w_stall;
    assign hz.flush_fd  = rst & hz.ex_redirect;
    assign hz.flush_dx  = rst & (w_stall | hz.ex_redirect);
    assign hz.fwd_a_sel = (rst && hz.id_valid) ? w_fwd_a : FWD_W'(FWD_RF);
    assign hz.fwd_b_sel = (rst && hz.id_valid) ? w_fwd_b : FWD_W'(FWD_RF);
    assign hz.busy_vec  = rst ? w_busy : '0;

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// tb/tb_pipe_hazard_unit.sv - directed bench with issue-history model for pipe_hazard_unit
module tb_pipe_hazard_unit;

    localparam int NREG = 32;
    localparam int PD   = 3;
    localparam int LS   = 2;

    logic clk;
    logic rst;

    pipe_hazard_unit_if #(.NREG(NREG), .PIPE_DEPTH(PD)) bus ();

    pipe_hazard_unit #(.NREG(NREG), .PIPE_DEPTH(PD), .LOAD_STAGE(LS)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Issued instructions: stage during the current cycle is cyc - issue cycle
    int q_issue[$];
    int q_rd[$];
    bit q_we[$];
    bit q_ld[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void find(input int src, input bit used, output int stg, output bit ld);
        stg = 0;
        ld  = 0;
        if (!used || src == 0) return;
        for (int i = 0; i < q_rd.size(); i++) begin
            int s;
            s = cyc - q_issue[i];
            if (s >= 1 && s <= PD && q_we[i] && q_rd[i] == src && (stg == 0 || s < stg)) begin
                stg = s;
                ld  = q_ld[i];
            end
        end
    endfunction

    task automatic model_exp(output bit e_stall, output bit e_ffd, output bit e_fdx,
                             output int e_fa, output int e_fb, output logic [31:0] e_busy);
        int sa, sb;
        bit la, lb, hzd;
        find(int'(bus.id_rs1), bus.id_rs1_used, sa, la);
        find(int'(bus.id_rs2), bus.id_rs2_used, sb, lb);
`ifdef HAZARD_FWD_EN
        hzd  = (sa != 0 && la && sa < LS) || (sb != 0 && lb && sb < LS);
        e_fa = bus.id_valid ? sa : 0;
        e_fb = bus.id_valid ? sb : 0;
`else
        hzd  = (sa != 0 && sa < PD) || (sb != 0 && sb < PD);
        e_fa = 0;
        e_fb = 0;
`endif
        e_ffd   = bus.ex_redirect;
        e_stall = bus.id_valid && hzd && !bus.ex_redirect;
        e_fdx   = e_stall || e_ffd;
        e_busy  = '0;
        for (int i = 0; i < q_rd.size(); i++) begin
            int s;
            s = cyc - q_issue[i];
            if (s >= 1 && s <= PD && q_we[i]) e_busy[q_rd[i]] = 1'b1;
        end
        if (!rst) begin
            e_stall = 0; e_ffd = 0; e_fdx = 0; e_fa = 0; e_fb = 0; e_busy = '0;
        end
    endtask

    task automatic clear_model();
        q_issue.delete();
        q_rd.delete();
        q_we.delete();
        q_ld.delete();
    endtask

    always @(negedge clk) begin : compare
        bit s, f1, f2;
        int a, b;
        logic [31:0] bz;
        model_exp(s, f1, f2, a, b, bz);
        chk("stall_fd", bus.stall_fd, s);
        chk("flush_fd", bus.flush_fd, f1);
        chk("flush_dx", bus.flush_dx, f2);
        chk("fwd_a_sel", bus.fwd_a_sel, a);
        chk("fwd_b_sel", bus.fwd_b_sel, b);
        chk("busy_vec", bus.busy_vec, bz);
        if (!rst) clear_model();
    end

    always @(posedge clk) begin : model_update
        bit s, f1, f2;
        int a, b;
        logic [31:0] bz;
        if (!rst) begin
            clear_model();
        end else begin
            model_exp(s, f1, f2, a, b, bz);
            while (q_issue.size() > 0 && cyc - q_issue[0] >= PD) begin
                void'(q_issue.pop_front());
                void'(q_rd.pop_front());
                void'(q_we.pop_front());
                void'(q_ld.pop_front());
            end
            if (bus.id_valid && !s && !bus.ex_redirect) begin
                q_issue.push_back(cyc);
                q_rd.push_back(int'(bus.id_rd));
                q_we.push_back(bus.id_rd_we && bus.id_rd != 0);
                q_ld.push_back(bus.id_is_load);
            end
        end
        cyc++;
    end

    task automatic ins(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                       input int rd, input bit we, input bit ld, input bit redir);
        @(posedge clk);
        #1;
        bus.id_valid    = v;
        bus.id_rs1      = 5'(rs1);
        bus.id_rs1_used = u1;
        bus.id_rs2      = 5'(rs2);
        bus.id_rs2_used = u2;
        bus.id_rd       = 5'(rd);
        bus.id_rd_we    = we;
        bus.id_is_load  = ld;
        bus.ex_redirect = redir;
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) ins(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b0;
        bus.id_valid = 0; bus.id_rs1 = 0; bus.id_rs1_used = 0; bus.id_rs2 = 0;
        bus.id_rs2_used = 0; bus.id_rd = 0; bus.id_rd_we = 0; bus.id_is_load = 0;
        bus.ex_redirect = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_flush_fd", bus.flush_fd, 0);
        chk("rst_flush_dx", bus.flush_dx, 0);
        chk("rst_busy", bus.busy_vec, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.ex_redirect = 1'b0;

        // add x5,x1,x2 ; sub x6,x5,x3
        ins(1, 1, 1, 2, 1, 5, 1, 0, 0);
`ifdef HAZARD_FWD_EN
        ins(1, 5, 1, 3, 1, 6, 1, 0, 0);
        chk("s1_fwd_a", bus.fwd_a_sel, 1);
        chk("s1_stall", bus.stall_fd, 0);
        ins(1, 5, 1, 0, 0, 10, 1, 0, 0);
        chk("s1_fwd_a_stage2", bus.fwd_a_sel, 2);
`else
        ins(1, 5, 1, 3, 1, 6, 1, 0, 0);
        chk("s1_stall_c1", bus.stall_fd, 1);
        ins(1, 5, 1, 3, 1, 6, 1, 0, 0);
        chk("s1_stall_c2", bus.stall_fd, 1);
        ins(1, 5, 1, 3, 1, 6, 1, 0, 0);
        chk("s1_stall_c3", bus.stall_fd, 0);
        chk("s1_fwd_a", bus.fwd_a_sel, 0);
`endif
        idle(3);

        // lw x7,0(x1) ; add x8,x7,x7
        ins(1, 1, 1, 0, 0, 7, 1, 1, 0);
        ins(1, 7, 1, 7, 1, 8, 1, 0, 0);
        chk("s2_stall", bus.stall_fd, 1);
        chk("s2_flush_dx", bus.flush_dx, 1);
        chk("s2_busy7_a", bus.busy_vec[7], 1);
`ifdef HAZARD_FWD_EN
        ins(1, 7, 1, 7, 1, 8, 1, 0, 0);
        chk("s2_stall_done", bus.stall_fd, 0);
        chk("s2_flush_dx_done", bus.flush_dx, 0);
        chk("s2_fwd_a", bus.fwd_a_sel, 2);
        chk("s2_fwd_b", bus.fwd_b_sel, 2);
        chk("s2_busy7_b", bus.busy_vec[7], 1);
`else
        ins(1, 7, 1, 7, 1, 8, 1, 0, 0);
        chk("s2_stall_c2", bus.stall_fd, 1);
        ins(1, 7, 1, 7, 1, 8, 1, 0, 0);
        chk("s2_stall_done", bus.stall_fd, 0);
`endif
        ins(0, 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef HAZARD_FWD_EN
        chk("s2_busy7_c", bus.busy_vec[7], 1);
        ins(0, 0, 0, 0, 0, 0, 0, 0, 0);
`endif
        chk("s2_busy7_off", bus.busy_vec[7], 0);
        idle(3);

        // addi x0,x0,5 ; add x9,x0,x0
        ins(1, 0, 1, 0, 0, 0, 1, 0, 0);
        ins(1, 0, 1, 0, 1, 9, 1, 0, 0);
        chk("s3_stall", bus.stall_fd, 0);
        chk("s3_fwd_a", bus.fwd_a_sel, 0);
        chk("s3_fwd_b", bus.fwd_b_sel, 0);
        chk("s3_busy", bus.busy_vec, 0);
        idle(3);

        // two writers of x4, then a reader
        ins(1, 1, 1, 0, 0, 4, 1, 0, 0);
        ins(1, 2, 1, 0, 0, 4, 1, 0, 0);
        ins(1, 4, 1, 0, 0, 12, 1, 0, 0);
`ifdef HAZARD_FWD_EN
        chk("s4_fwd_youngest", bus.fwd_a_sel, 1);
        chk("s4_stall", bus.stall_fd, 0);
`else
        chk("s4_stall", bus.stall_fd, 1);
`endif
        idle(4);

        // load-use coincident with redirect
        ins(1, 1, 1, 0, 0, 7, 1, 1, 0);
        ins(1, 7, 1, 0, 0, 8, 1, 0, 1);
        chk("s5_stall", bus.stall_fd, 0);
        chk("s5_flush_fd", bus.flush_fd, 1);
        chk("s5_flush_dx", bus.flush_dx, 1);
        ins(1, 8, 1, 0, 0, 9, 1, 0, 0);
        chk("s5_bubble_busy", bus.busy_vec, 32'h0000_0080);
        chk("s5_bubble_fwd", bus.fwd_a_sel, 0);
        idle(3);

        // asynchronous reset with three writers in flight
        ins(1, 1, 1, 0, 0, 11, 1, 0, 0);
        ins(1, 1, 1, 0, 0, 12, 1, 0, 0);
        ins(1, 1, 1, 0, 0, 13, 1, 0, 0);
        chk("s6_busy_pre", bus.busy_vec, 32'h0000_1800);
        @(posedge clk);
        #1;
        bus.id_rs1 = 5'd13;
        bus.id_rd  = 5'd14;
        rst = 1'b0;
        #1;
        chk("s6_rst_busy", bus.busy_vec, 0);
        chk("s6_rst_fwd", bus.fwd_a_sel, 0);
        chk("s6_rst_stall", bus.stall_fd, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("s6_post_busy", bus.busy_vec, 0);
        chk("s6_post_fwd", bus.fwd_a_sel, 0);
        ins(1, 11, 1, 12, 1, 15, 1, 0, 0);
        chk("s6_post_fwd_a", bus.fwd_a_sel, 0);
        chk("s6_post_fwd_b", bus.fwd_b_sel, 0);
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
